imem_pgm: RTL and testbench
===========================

Name: imem_pgm

Overview:
- Parametrised successor to the fixed 16-bit instruction memory: synchronous-read instruction store with a run-time programming port.
- Loader streams words in over a valid/ready handshake; no file read inside the RTL.
- Reset zero-fills the array with a hardware clear sequence, one entry per cycle.
- Sits between the fetch stage (read port, with stall) and the boot/debug loader (programming port).

Parameters:
- DATA_W, 16, instruction width in bits
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries
- NOP_WORD, 0 (DATA_W wide), value driven on data_out while not ready and loaded by the clear sequence

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  fetch enable; low = stall, data_out holds
- address  in  ADDR_W  fetch address
- data_out  out  DATA_W  registered instruction
- rd_valid  out  1  data_out holds a word read in RUN
- mem_ready  out  1  high only in RUN
- pgm_start  in  1  pulse, begins a load at pgm_base
- pgm_base  in  ADDR_W  first write address, sampled with pgm_start
- pgm_valid  in  1  loader word valid
- pgm_data  in  DATA_W  loader word
- pgm_last  in  1  marks final word, qualified by pgm_valid
- pgm_ready  out  1  high only in LOAD
- pgm_count  out  ADDR_W+1  words accepted in current/last load, saturates at DEPTH
- pgm_wrap  out  1  sticky: write pointer wrapped DEPTH-1 -> 0 during this load

Behaviour:
- Reset, in the rst cycle: state=CLEAR, clr_ptr=0, data_out=NOP_WORD, rd_valid=0, mem_ready=0, pgm_ready=0, pgm_count=0, pgm_wrap=0.
- rst asserted mid-LOAD or mid-CLEAR restarts CLEAR; any partial load is discarded.
- CLEAR state:
  - Writes NOP_WORD to mem[clr_ptr] and increments clr_ptr each cycle.
  - After writing DEPTH-1, moves to RUN; total DEPTH cycles after rst deasserts.
  - pgm_start and rd_en are ignored.
- RUN state:
  - mem_ready=1.
  - rd_en=1: data_out <= mem[address] and rd_valid <= 1, 1-cycle latency.
  - rd_en=0: data_out and rd_valid hold.
  - pgm_start=1: next state LOAD, wptr <= pgm_base, pgm_count <= 0, pgm_wrap <= 0, rd_valid <= 0. pgm_start wins over rd_en in the same cycle; no read is performed.
- LOAD state:
  - pgm_ready=1, mem_ready=0; data_out holds NOP_WORD (loaded on entry), rd_valid=0.
  - Accept on pgm_valid && pgm_ready: mem[wptr] <= pgm_data, wptr <= wptr+1 mod DEPTH, pgm_count += 1 (saturating at DEPTH).
  - If the accepted wptr == DEPTH-1, set pgm_wrap. Writes continue; earlier words may be overwritten.
  - Accepted word with pgm_last=1: written, then RUN on the next cycle.
  - pgm_last without pgm_valid is ignored. pgm_start while in LOAD is ignored.
- A read in the first RUN cycle after LOAD returns the freshly written data; there is no read-during-write hazard because reads and writes never share a cycle.
- Address width is exact; no out-of-range addresses exist.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on pgm_data and NOP_WORD writes.
  - Added output parity_err (1 bit), registered with data_out.
  - parity_err=1 when a RUN read's stored parity mismatches its data; it holds with data_out during stalls; reset value 0.
  - Added input inj_perr (1 bit): when high during an accepted pgm write, the stored parity bit is inverted.
- Undefined: no parity storage, no parity_err or inj_perr ports; behaviour otherwise identical.

Test Plan:
- Reset then idle (ADDR_W=8) -> mem_ready rises exactly 256 cycles after rst falls; reads of addresses 0x00, 0x7F and 0xFF return 0x0000 with rd_valid=1 one cycle later.
- pgm_start, base 0x10, stream 0x1111/0x2222/0x3333 with last on the third word, pgm_valid toggled 1,0,1,0,1 -> pgm_count=3, RUN next cycle; reading 0x10..0x12 returns the words in order, 0x13 returns 0x0000.
- Read 0x11, then rd_en=0 for 4 cycles with address changing -> data_out stays 0x2222 and rd_valid stays 1.
- Base 0xFE, 4 words 0xA0..0xA3 -> pgm_wrap=1 after the 0xFF write; 0xFE=0xA0, 0xFF=0xA1, 0x00=0xA2, 0x01=0xA3.
- rst asserted after 2 of 5 load words -> CLEAR reruns; after ready, address 0x10 reads 0x0000 and pgm_count=0.
- IMEM_PARITY_EN: write 0x00FF with inj_perr=1 at 0x20 and 0x00FF at 0x21 -> read 0x20 gives parity_err=1, read 0x21 gives parity_err=0.

Source files
------------

// File: rtl/imem_pgm.sv
// Synchronous-read instruction memory with a zero-fill clear sequence and a
// valid/ready programming port. Define IMEM_PARITY_EN to add per-entry even parity.
module imem_pgm #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              mem_ready,
  input  logic              pgm_start,
  input  logic [ADDR_W-1:0] pgm_base,
  input  logic              pgm_valid,
  input  logic [DATA_W-1:0] pgm_data,
  input  logic              pgm_last,
  output logic              pgm_ready,
  output logic [ADDR_W:0]   pgm_count,
`ifdef IMEM_PARITY_EN
  input  logic              inj_perr,
  output logic              parity_err,
`endif
  output logic              pgm_wrap
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wrap_q, wrap_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;

`ifdef IMEM_PARITY_EN
  logic                par_mem [DEPTH];
  logic                wpar;
  logic                rpar;
  logic                perr_q, perr_d;
  assign rpar       = par_mem[address];
  assign parity_err = perr_q;
`endif

  assign rdata     = mem[address];
  assign data_out  = data_q;
  assign rd_valid  = rd_valid_q;
  assign mem_ready = (state_q == S_RUN);
  assign pgm_ready = (state_q == S_LOAD);
  assign pgm_count = cnt_q;
  assign pgm_wrap  = wrap_q;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wptr_d     = wptr_q;
    data_d     = data_q;
    rd_valid_d = rd_valid_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    we         = 1'b0;
    waddr      = clr_ptr_q;
    wdata      = NOP_WORD;
`ifdef IMEM_PARITY_EN
    wpar       = ^NOP_WORD;
    perr_d     = perr_q;
`endif
    case (state_q)
      S_CLEAR: begin
        we        = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        // pgm_start takes priority: no read happens on the cycle a load begins
        if (pgm_start) begin
          state_d    = S_LOAD;
          wptr_d     = pgm_base;
          cnt_d      = '0;
          wrap_d     = 1'b0;
          rd_valid_d = 1'b0;
          data_d     = NOP_WORD;
`ifdef IMEM_PARITY_EN
          perr_d     = 1'b0;
`endif
        end else if (rd_en) begin
          data_d     = rdata;
          rd_valid_d = 1'b1;
`ifdef IMEM_PARITY_EN
          perr_d     = ^{rdata, rpar};
`endif
        end
      end
      S_LOAD: begin
        if (pgm_valid) begin
          we     = 1'b1;
          waddr  = wptr_q;
          wdata  = pgm_data;
`ifdef IMEM_PARITY_EN
          wpar   = (^pgm_data) ^ inj_perr;
`endif
          wptr_d = wptr_q + 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (wptr_q == '1) wrap_d = 1'b1;
          if (pgm_last) state_d = S_RUN;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      wptr_q     <= '0;
      data_q     <= NOP_WORD;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
`ifdef IMEM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wptr_q     <= wptr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
`ifdef IMEM_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // Storage kept reset-free so it can map onto block RAM; the clear sequence zero-fills it.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
`ifdef IMEM_PARITY_EN
      par_mem[waddr] <= wpar;
`endif
    end
  end

endmodule

// File: tb/tb_imem_pgm.sv
// Randomized self-checking bench for imem_pgm against an array-based reference model.
module tb_imem_pgm;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, rd_en, pgm_start, pgm_valid, pgm_last;
  logic [AW-1:0] address, pgm_base;
  logic [DW-1:0] pgm_data, data_out;
  logic          rd_valid, mem_ready, pgm_ready, pgm_wrap;
  logic [AW:0]   pgm_count;
`ifdef IMEM_PARITY_EN
  logic          inj_perr, parity_err;
`endif

  always #5 clk = ~clk;

  imem_pgm #(.DATA_W(DW), .ADDR_W(AW), .NOP_WORD('0)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .address(address),
    .data_out(data_out), .rd_valid(rd_valid), .mem_ready(mem_ready),
    .pgm_start(pgm_start), .pgm_base(pgm_base), .pgm_valid(pgm_valid),
    .pgm_data(pgm_data), .pgm_last(pgm_last), .pgm_ready(pgm_ready),
    .pgm_count(pgm_count),
`ifdef IMEM_PARITY_EN
    .inj_perr(inj_perr), .parity_err(parity_err),
`endif
    .pgm_wrap(pgm_wrap)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem  [DEPTH];
  bit            ref_perr [DEPTH];
  int            ref_count;
  bit            ref_wrap;
  logic [DW-1:0] wbuf [300];
  bit            winj [300];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mem_ready", mem_ready, 0);
    check_eq("rst_pgm_ready", pgm_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_pgm_count", pgm_count, 0);
    check_eq("rst_pgm_wrap", pgm_wrap, 0);
    n = 0;
    while (!mem_ready && n < 300) begin
      rd_en = 1'($urandom);
      pgm_start = 1'($urandom);
      address = 8'($urandom);
      step();
      n++;
    end
    rd_en = 1'b0;
    pgm_start = 1'b0;
    check_eq("clear_cycles", n, 256);
    check_eq("clear_rd_valid", rd_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_perr[i] = 1'b0;
    end
    ref_count = 0;
    ref_wrap = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    address = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq($sformatf("rd_data@%0h", a), data_out, ref_mem[a]);
    check_eq($sformatf("rd_valid@%0h", a), rd_valid, 1);
`ifdef IMEM_PARITY_EN
    check_eq($sformatf("rd_perr@%0h", a), parity_err, ref_perr[a]);
`endif
  endtask

  // gap_mode: 0 = back-to-back, 1 = one idle cycle between words, 2 = random idles
  task automatic load(input logic [AW-1:0] base, input int n, input int gap_mode);
    int wp, gaps;
    pgm_base = base;
    pgm_start = 1'b1;
    rd_en = 1'($urandom);
    step();
    pgm_start = 1'b0;
    check_eq("ld_entry_ready", pgm_ready, 1);
    check_eq("ld_entry_mem_ready", mem_ready, 0);
    check_eq("ld_entry_rd_valid", rd_valid, 0);
    check_eq("ld_entry_data", data_out, 0);
    check_eq("ld_entry_count", pgm_count, 0);
    check_eq("ld_entry_wrap", pgm_wrap, 0);
    ref_count = 0;
    ref_wrap = 1'b0;
    wp = int'(base);
    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        pgm_valid = 1'b0;
        pgm_last = 1'($urandom);
        pgm_start = 1'($urandom);
        rd_en = 1'($urandom);
        pgm_data = 16'($urandom);
        step();
        check_eq("ld_gap_ready", pgm_ready, 1);
        check_eq("ld_gap_data", data_out, 0);
      end
      pgm_valid = 1'b1;
      pgm_data = wbuf[i];
      pgm_last = (i == n - 1);
      pgm_start = 1'($urandom);
      rd_en = 1'($urandom);
`ifdef IMEM_PARITY_EN
      inj_perr = winj[i];
`endif
      step();
      ref_mem[wp] = wbuf[i];
      ref_perr[wp] = winj[i];
      if (wp == DEPTH - 1) ref_wrap = 1'b1;
      wp = (wp + 1) % DEPTH;
      if (ref_count < DEPTH) ref_count++;
    end
    pgm_valid = 1'b0;
    pgm_last = 1'b0;
    pgm_start = 1'b0;
    rd_en = 1'b0;
`ifdef IMEM_PARITY_EN
    inj_perr = 1'b0;
`endif
    check_eq("ld_done_mem_ready", mem_ready, 1);
    check_eq("ld_done_pgm_ready", pgm_ready, 0);
    check_eq("ld_done_rd_valid", rd_valid, 0);
    check_eq("ld_done_count", pgm_count, ref_count);
    check_eq("ld_done_wrap", pgm_wrap, ref_wrap);
  endtask

  initial begin
    int n;
    rst = 1'b1; rd_en = 1'b0; pgm_start = 1'b0; pgm_valid = 1'b0; pgm_last = 1'b0;
    address = '0; pgm_base = '0; pgm_data = '0;
`ifdef IMEM_PARITY_EN
    inj_perr = 1'b0;
`endif
    for (int i = 0; i < 300; i++) winj[i] = 1'b0;

    do_reset();
    rd(8'h00); rd(8'h7F); rd(8'hFF);

    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    load(8'h10, 3, 1);
    check_eq("t2_count", pgm_count, 3);
    rd(8'h10); rd(8'h11); rd(8'h12); rd(8'h13);

    rd(8'h11);
    for (int i = 0; i < 4; i++) begin
      address = 8'($urandom);
      rd_en = 1'b0;
      step();
      check_eq("stall_data", data_out, 16'h2222);
      check_eq("stall_valid", rd_valid, 1);
    end

    for (int i = 0; i < 4; i++) wbuf[i] = 16'(16'hA0 + i);
    load(8'hFE, 4, 0);
    check_eq("wrap_flag", pgm_wrap, 1);
    rd(8'hFE); rd(8'hFF); rd(8'h00); rd(8'h01);

    for (int i = 0; i < 260; i++) wbuf[i] = 16'($urandom);
    load(8'h00, 260, 0);
    check_eq("sat_count", pgm_count, 256);
    rd(8'h00); rd(8'h03); rd(8'h04); rd(8'hFF);

    for (int it = 0; it < 15; it++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
`ifdef IMEM_PARITY_EN
        winj[i] = 1'($urandom);
`endif
      end
      load(8'($urandom), n, 2);
      for (int r = 0; r < 6; r++) rd(8'($urandom));
    end

`ifdef IMEM_PARITY_EN
    wbuf[0] = 16'h00FF; winj[0] = 1'b1;
    wbuf[1] = 16'h00FF; winj[1] = 1'b0;
    load(8'h20, 2, 0);
    rd(8'h20);
    check_eq("perr_inj", parity_err, 1);
    rd(8'h21);
    check_eq("perr_clean", parity_err, 0);
    for (int i = 0; i < 300; i++) winj[i] = 1'b0;
`endif

    pgm_base = 8'h10;
    pgm_start = 1'b1;
    step();
    pgm_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pgm_valid = 1'b1;
      pgm_data = 16'($urandom | 1);
      pgm_last = 1'b0;
      step();
    end
    pgm_valid = 1'b0;
    do_reset();
    check_eq("midrst_count", pgm_count, 0);
    rd(8'h10);
    rd(8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
